riscv_core_issue_ctrl: RTL

Two-slot in-order issue window and steering controller for the IO2I dual-issue core. It sits between decode and the X0 stage, holding the current decoded pair and driving the scoreboard's source, destination, issue and steer inputs. Each cycle it decides which instructions issue and routes them onto pipeline A or pipeline B, using the scoreboard stall outputs and intra-pair hazard checks. A partially issued pair is compacted: the younger instruction moves into the older slot.

---
 rtl/riscv_core_issue_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/riscv_core_issue_ctrl.sv
// Two-slot in-order issue window for the dual-issue core.
// Steers issued instructions onto pipe A (any) and pipe B (ALU only).
module riscv_core_issue_ctrl #(
  parameter int W_PAYLOAD = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_val0,
  input  logic                 in_val1,
  input  logic [4:0]           in_src0_srcA,
  input  logic                 in_src0_srcA_en,
  input  logic [4:0]           in_src0_srcB,
  input  logic                 in_src0_srcB_en,
  input  logic [4:0]           in_src0_dst,
  input  logic                 in_src0_dst_en,
  input  logic [1:0]           in_src0_func,
  input  logic [W_PAYLOAD-1:0] in_src0_payload,
  input  logic [4:0]           in_src1_srcA,
  input  logic                 in_src1_srcA_en,
  input  logic [4:0]           in_src1_srcB,
  input  logic                 in_src1_srcB_en,
  input  logic [4:0]           in_src1_dst,
  input  logic                 in_src1_dst_en,
  input  logic [1:0]           in_src1_func,
  input  logic [W_PAYLOAD-1:0] in_src1_payload,
  output logic                 in_rdy,
  input  logic                 flush,
  input  logic                 stall_X0hl,
  input  logic                 stall_ir0,
  input  logic                 stall_ir1,
  output logic [4:0]           src00,
  output logic [4:0]           src01,
  output logic [4:0]           src10,
  output logic [4:0]           src11,
  output logic                 src00_en,
  output logic                 src01_en,
  output logic                 src10_en,
  output logic                 src11_en,
  output logic [4:0]           dst0,
  output logic [4:0]           dst1,
  output logic                 dst0_en,
  output logic                 dst1_en,
  output logic [1:0]           func_ir0,
  output logic [1:0]           func_ir1,
  output logic                 inst_val_Dhl,
  output logic                 ir0_issued,
  output logic                 ir1_issued,
  output logic                 steer_signal,
  output logic                 issA_val,
  output logic                 issB_val,
  output logic [W_PAYLOAD-1:0] issA_payload,
  output logic [W_PAYLOAD-1:0] issB_payload,
  output logic [31:0]          dual_cnt,
  output logic [31:0]          single_cnt
);

  typedef struct packed {
    logic [4:0]           srca;
    logic                 srca_en;
    logic [4:0]           srcb;
    logic                 srcb_en;
    logic [4:0]           dst;
    logic                 dst_en;
    logic [1:0]           func;
    logic [W_PAYLOAD-1:0] payload;
  } slot_t;

  slot_t s0, s1, in0, in1;
  logic  v0q, v1q, v0, v1;
  logic  alu0, alu1, raw, waw, strct;

  assign in0 = '{in_src0_srcA, in_src0_srcA_en, in_src0_srcB,
                 in_src0_srcB_en, in_src0_dst, in_src0_dst_en,
                 in_src0_func, in_src0_payload};
  assign in1 = '{in_src1_srcA, in_src1_srcA_en, in_src1_srcB,
                 in_src1_srcB_en, in_src1_dst, in_src1_dst_en,
                 in_src1_func, in_src1_payload};

  assign v0 = v0q && !reset;
  assign v1 = v1q && !reset;

  assign src00    = s0.srca;
  assign src01    = s0.srcb;
  assign src10    = s1.srca;
  assign src11    = s1.srcb;
  assign src00_en = s0.srca_en;
  assign src01_en = s0.srcb_en;
  assign src10_en = s1.srca_en;
  assign src11_en = s1.srcb_en;
  assign dst0     = s0.dst;
  assign dst1     = s1.dst;
  assign dst0_en  = s0.dst_en;
  assign dst1_en  = s1.dst_en;
  assign func_ir0 = s0.func;
  assign func_ir1 = s1.func;
  assign inst_val_Dhl = v0;

  assign alu0  = s0.func == 2'b00;
  assign alu1  = s1.func == 2'b00;
  assign raw   = s0.dst_en && s0.dst != 5'd0 &&
                 ((s1.srca_en && s1.srca == s0.dst) ||
                  (s1.srcb_en && s1.srcb == s0.dst));
  assign waw   = s0.dst_en && s1.dst_en &&
                 s0.dst == s1.dst && s0.dst != 5'd0;
  assign strct = !alu0 && !alu1;

  assign ir0_issued = v0 && !stall_ir0 && !stall_X0hl && !flush;
  assign ir1_issued = ir0_issued && v1 && !stall_ir1 &&
                      !raw && !waw && !strct;
  // Pipe B is ALU-only, so a non-ALU younger op must take pipe A.
  assign steer_signal = v0 && alu0 && v1 && !alu1;
  assign in_rdy = !reset && !flush &&
                  (!v0 || (ir0_issued && (ir1_issued || !v1)));

  always_comb begin
    issA_val     = 1'b0;
    issB_val     = 1'b0;
    issA_payload = '0;
    issB_payload = '0;
    if (steer_signal) begin
      issB_val = ir0_issued;
      issA_val = ir1_issued;
      if (ir0_issued) issB_payload = s0.payload;
      if (ir1_issued) issA_payload = s1.payload;
    end else begin
      issA_val = ir0_issued;
      issB_val = ir1_issued;
      if (ir0_issued) issA_payload = s0.payload;
      if (ir1_issued) issB_payload = s1.payload;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      v0q <= 1'b0;
      v1q <= 1'b0;
    end else if (in_rdy && in_val0) begin
      v0q <= 1'b1;
      v1q <= in_val1;
      s0  <= in0;
      s1  <= in1;
    end else if (in_rdy) begin
      v0q <= 1'b0;
      v1q <= 1'b0;
    end else if (ir0_issued && !ir1_issued && v1q) begin
      s0  <= s1;
      v1q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dual_cnt   <= '0;
      single_cnt <= '0;
    end else if (ir0_issued && ir1_issued) begin
      dual_cnt   <= dual_cnt + 32'd1;
    end else if (ir0_issued) begin
      single_cnt <= single_cnt + 32'd1;
    end
  end

endmodule
